// File: rtl/bcd_disp_pkg.sv
// Shared types and seven-segment glyphs for the BCD display scanner.
// Glyph bit order is {a,b,c,d,e,f,g}, active-high, segment a in bit 6.
package bcd_disp_pkg;

   localparam int SEG_W = 7;

   typedef logic [3:0]       bcd_t;
   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_0     = 7'h7E;
   localparam seg_t SEG_1     = 7'h30;
   localparam seg_t SEG_2     = 7'h6D;
   localparam seg_t SEG_3     = 7'h79;
   localparam seg_t SEG_4     = 7'h33;
   localparam seg_t SEG_5     = 7'h5B;
   localparam seg_t SEG_6     = 7'h5F;
   localparam seg_t SEG_7     = 7'h70;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h7B;
   localparam seg_t SEG_DASH  = 7'h01;
   localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Digit-data and display-pin bundle between the counter bank and the scanner.
// master = producer/board side, slave = the scanner itself.
interface bcd_display_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   import bcd_disp_pkg::*;

   logic [4*NUM_DIGITS-1:0] digits_in;
   logic                    update;
   logic                    blank_lz;
   logic                    upd_ack;
   seg_t                    seg;
   logic [NUM_DIGITS-1:0]   an;

   modport master (
      output digits_in, update, blank_lz,
      input  upd_ack, seg, an
   );

   modport slave (
      input  digits_in, update, blank_lz,
      output upd_ack, seg, an
   );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; codes 10-15 render as a dash.
module bcd_to_seg
   import bcd_disp_pkg::*;
(
   input  bcd_t bcd,
   output seg_t seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed seven-segment scanner: frame-atomic snapshot of packed BCD digits,
// one-hot digit scan, leading-zero blanking and a delayed update acknowledge.
module bcd_display_scanner
   import bcd_disp_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   bcd_display_scanner_if.slave  bus
);

   localparam int DATA_W = 4 * NUM_DIGITS;
   localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [DIV_W-1:0]      div_q,        div_d;
   logic [IDX_W-1:0]      idx_q,        idx_d;
   logic [DATA_W-1:0]     shadow_q,     shadow_d;
   logic [DATA_W-1:0]     pend_q,       pend_d;
   logic                  pend_valid_q, pend_valid_d;
   logic                  ack_arm_q,    ack_arm_d;
   logic                  upd_ack_q,    upd_ack_d;
   seg_t                  seg_q,        seg_d;
   logic [NUM_DIGITS-1:0] an_q,         an_d;

   logic digit_end;
   logic frame_end;

   bcd_t                  shadow_digit [NUM_DIGITS];
   bcd_t                  cur_digit;
   seg_t                  cur_glyph;
   logic [NUM_DIGITS:1]   zero_from;
   logic [NUM_DIGITS-1:0] lz_mask;

   assign zero_from[NUM_DIGITS] = 1'b1;

   // lz_mask[i] is set when digit i and everything above it is zero; digit 0 is never blanked.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign shadow_digit[gi] = shadow_q[4*gi +: 4];
         if (gi == 0) begin : g_lsd
            assign lz_mask[gi] = 1'b0;
         end else begin : g_upper
            assign zero_from[gi] = (shadow_digit[gi] == 4'd0) && zero_from[gi+1];
            assign lz_mask[gi]   = zero_from[gi];
         end
      end
   endgenerate

   assign cur_digit = shadow_digit[idx_q];
   assign digit_end = (div_q == DIV_LAST);
   assign frame_end = digit_end && (idx_q == IDX_LAST);

   bcd_to_seg u_bcd_to_seg (
      .bcd (cur_digit),
      .seg (cur_glyph)
   );

   always_comb begin
      div_d        = digit_end ? '0 : div_q + 1'b1;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      ack_arm_d    = 1'b0;
      upd_ack_d    = ack_arm_q;
      an_d         = NUM_DIGITS'(1) << idx_q;
      seg_d        = (bus.blank_lz && lz_mask[idx_q]) ? SEG_BLANK : cur_glyph;

      if (digit_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      // Shadow only changes as idx wraps, so a frame never shows mixed snapshots.
      if (frame_end) begin
         if (bus.update) begin
            shadow_d     = bus.digits_in;
            pend_valid_d = 1'b0;
            ack_arm_d    = 1'b1;
         end else if (pend_valid_q) begin
            shadow_d     = pend_q;
            pend_valid_d = 1'b0;
            ack_arm_d    = 1'b1;
         end
      end else if (bus.update) begin
         pend_d       = bus.digits_in;
         pend_valid_d = 1'b1;
      end
   end

   // ack_arm delays the acknowledge one cycle so it lines up with an[0] rising.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         ack_arm_q    <= 1'b0;
         upd_ack_q    <= 1'b0;
         seg_q        <= SEG_BLANK;
         an_q         <= '0;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         ack_arm_q    <= ack_arm_d;
         upd_ack_q    <= upd_ack_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign bus.upd_ack = upd_ack_q;
   assign bus.seg     = seg_q;
   assign bus.an      = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized plus directed bench for bcd_display_scanner (4 digits, 4 cycles/digit),
// checked every cycle against a time-indexed frame model.
module tb_bcd_display_scanner;

   localparam int N     = 4;
   localparam int R     = 4;
   localparam int FRAME = N * R;

   localparam logic [6:0] GLYPH [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01
   };

   logic clk = 1'b0;
   logic reset;

   bcd_display_scanner_if #(.NUM_DIGITS(N)) bus ();

   bcd_display_scanner #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (R)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int          checks     = 0;
   int          failures   = 0;
   int          t          = 0;
   int          acks_seen  = 0;
   logic [15:0] shadow_m   = '0;
   logic [15:0] pend_m     = '0;
   bit          pv_m       = 1'b0;
   bit          ack_m      = 1'b0;
   bit          cur_blz    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
      end
   endtask

   // Glyph of digit i of value v, blanked when it and all higher digits are zero.
   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i, input bit blz);
      int d;
      d = int'((v >> (4 * i)) & 16'h000F);
      if (blz && i > 0 && (v >> (4 * i)) == 16'h0000) return 7'h00;
      return GLYPH[d];
   endfunction

   task automatic step(input bit upd, input logic [15:0] digs);
      int         idx;
      bit         boundary;
      logic [6:0] e_seg;
      logic [3:0] e_an;
      bit         e_ack;
      bus.update    = upd;
      bus.digits_in = digs;
      bus.blank_lz  = cur_blz;
      idx      = (t / R) % N;
      boundary = (t % FRAME) == FRAME - 1;
      e_an     = 4'(1 << idx);
      e_seg    = exp_seg(shadow_m, idx, cur_blz);
      e_ack    = ack_m;
      ack_m    = 1'b0;
      if (boundary) begin
         if (upd) begin
            shadow_m = digs; pv_m = 1'b0; ack_m = 1'b1;
         end else if (pv_m) begin
            shadow_m = pend_m; pv_m = 1'b0; ack_m = 1'b1;
         end
      end else if (upd) begin
         pend_m = digs; pv_m = 1'b1;
      end
      if (upd) $display("txn update digits=%h t=%0d boundary=%0d blank_lz=%0d", digs, t, boundary, cur_blz);
      @(posedge clk);
      #1;
      t++;
      check("an", 32'(bus.an), 32'(e_an));
      check("seg", 32'(bus.seg), 32'(e_seg));
      check("upd_ack", 32'(bus.upd_ack), 32'(e_ack));
      if (bus.upd_ack) acks_seen++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
   endtask

   task automatic run_to_phase(input int ph);
      for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) step(1'b0, 16'($urandom));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.update = 1'b0;
      @(posedge clk);
      #1;
      check("rst_an", 32'(bus.an), 32'd0);
      check("rst_seg", 32'(bus.seg), 32'd0);
      check("rst_ack", 32'(bus.upd_ack), 32'd0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      shadow_m = '0;
      pend_m   = '0;
      pv_m     = 1'b0;
      ack_m    = 1'b0;
      t        = 0;
      $display("txn reset released");
      check("first_an", 32'(bus.an), 32'd0);
      check("first_seg", 32'(bus.seg), 32'd0);
   endtask

   initial begin
      int a0;
      logic [15:0] mask;
      reset         = 1'b1;
      bus.digits_in = '0;
      bus.update    = 1'b0;
      bus.blank_lz  = 1'b0;
      do_reset();

      // Idle scan with all-zero shadow.
      a0 = acks_seen;
      idle(3 * FRAME);
      check("idle_acks", 32'(acks_seen - a0), 32'd0);

      // Single mid-frame update.
      a0 = acks_seen;
      run_to_phase(6);
      step(1'b1, 16'h1907);
      idle(2 * FRAME);
      check("ack_1907", 32'(acks_seen - a0), 32'd1);

      // Three updates in one frame: last wins, one ack.
      a0 = acks_seen;
      run_to_phase(2);
      step(1'b1, 16'h0001);
      idle(3);
      step(1'b1, 16'h0002);
      idle(2);
      step(1'b1, 16'h0003);
      idle(2 * FRAME);
      check("ack_triple", 32'(acks_seen - a0), 32'd1);

      // Leading-zero blanking, then live disable.
      cur_blz = 1'b1;
      run_to_phase(3);
      step(1'b1, 16'h0040);
      idle(2 * FRAME);
      cur_blz = 1'b0;
      idle(FRAME);

      // Illegal codes render as dash and count as nonzero.
      cur_blz = 1'b1;
      step(1'b1, 16'hA0F5);
      idle(2 * FRAME);
      cur_blz = 1'b0;

      // Update exactly on the boundary cycle.
      a0 = acks_seen;
      run_to_phase(FRAME - 1);
      step(1'b1, 16'h4321);
      idle(FRAME);
      check("ack_boundary", 32'(acks_seen - a0), 32'd1);

      // Pending update discarded by reset.
      a0 = acks_seen;
      run_to_phase(5);
      step(1'b1, 16'h9999);
      idle(2);
      do_reset();
      idle(2 * FRAME);
      check("ack_after_reset", 32'(acks_seen - a0), 32'd0);

      // Random traffic with biased leading zeros and occasional resets.
      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 3))
            0:       mask = 16'h000F;
            1:       mask = 16'h00FF;
            2:       mask = 16'h0FFF;
            default: mask = 16'hFFFF;
         endcase
         if ($urandom_range(0, 31) == 0) cur_blz = ~cur_blz;
         if ($urandom_range(0, 399) == 0) do_reset();
         step($urandom_range(0, 7) == 0, 16'($urandom) & mask);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
